// File: rtl/gpt_chan.sv
`default_nettype none
// ============================================================================
//  Module      : gpt_chan
//  Description : One gate channel. It counts gates over an interval and
//                saturates the count. On evaluation it compares the interval
//                total against the legal window and keeps the result, a
//                sticky error flag and the last total.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpt_chan #(
    parameter int CW      = 9,
    parameter int GPT_MIN = 16,
    parameter int GPT_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_gate,
    input  logic          i_trig,
    input  logic          i_clear,
    input  logic          i_eval,
    output logic          o_err_now,
    output logic          o_time_err,
    output logic          o_err_sticky,
    output logic [CW-1:0] o_last_count
);

    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_MIN     = CW'(GPT_MIN);
    localparam logic [CW-1:0] c_MAX     = CW'(GPT_MAX);

    logic [CW-1:0] r_count;
    logic          r_time_err;
    logic          r_err_sticky;
    logic [CW-1:0] r_last_count;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_total;
    logic          w_err;

    // A gate on the trig cycle still belongs to the interval that is ending,
    // so the total is count+gate. The extra sum bit catches the overflow
    // that forces saturation.
    assign w_sum   = {1'b0, r_count} + {{CW{1'b0}}, i_gate};
    assign w_total = w_sum[CW] ? c_CNT_MAX : w_sum[CW-1:0];
    assign w_err   = (w_total < c_MIN) || (w_total > c_MAX);

    // Interval counter: restarts after every trig and whenever sync is lost.
    always_ff @(posedge clk) begin
        if (rst || i_clear || i_trig) begin
            r_count <= '0;
        end else if (i_gate && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Evaluation results. Clear wipes only the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_time_err   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_last_count <= '0;
        end else if (i_clear) begin
            r_err_sticky <= 1'b0;
        end else if (i_eval) begin
            r_time_err   <= w_err;
            r_last_count <= w_total;
            r_err_sticky <= r_err_sticky | w_err;
        end
    end

    assign o_err_now    = w_err;
    assign o_time_err   = r_time_err;
    assign o_err_sticky = r_err_sticky;
    assign o_last_count = r_last_count;

endmodule
`default_nettype wire

// File: rtl/gpt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : gpt_monitor
//  Description : Gates-per-trig monitor. It checks that every channel sees
//                a legal number of gate strobes between consecutive trigs.
//                The first trig after reset or clear only establishes sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpt_monitor #(
    parameter int NCH     = 4,
    parameter int CW      = 9,
    parameter int GPT_MIN = 16,
    parameter int GPT_MAX = 16,
    parameter int ECW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    gate,
    input  logic              trig,
    input  logic              clear,
    output logic              valid,
    output logic [NCH-1:0]    time_err,
    output logic [NCH-1:0]    err_sticky,
    output logic [ECW-1:0]    err_count,
    output logic [NCH*CW-1:0] last_count
);

    localparam logic [0:0]     c_ST_UNSYNCED = 1'b0;
    localparam logic [0:0]     c_ST_SYNCED   = 1'b1;
    localparam logic [ECW-1:0] c_EC_MAX      = {ECW{1'b1}};

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic           w_eval;
    logic           r_valid;
    logic [ECW-1:0] r_err_count;
    logic [NCH-1:0] w_err_now;

    // Reject a window that is inverted or that a CW-bit counter cannot reach.
    generate
        if ((GPT_MIN > GPT_MAX) || (GPT_MAX > ((2 ** CW) - 1))) begin : g_param_check
            $error("gpt_monitor: need GPT_MIN <= GPT_MAX <= 2**CW-1");
        end
    endgenerate

    // Sync state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_UNSYNCED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and evaluate strobe. Clear overrides a coincident trig.
    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        if (clear) begin
            w_state_nxt = c_ST_UNSYNCED;
        end else if (trig) begin
            if (r_state == c_ST_UNSYNCED) begin
                w_state_nxt = c_ST_SYNCED;
            end else begin
                w_eval = 1'b1;
            end
        end
    end

    // Result pulse and saturating count of evaluations that had an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_valid <= w_eval;
            if (clear) begin
                r_err_count <= '0;
            end else if (w_eval && (|w_err_now) && (r_err_count != c_EC_MAX)) begin
                r_err_count <= r_err_count + ECW'(1);
            end
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_chan
            gpt_chan #(
                .CW      (CW),
                .GPT_MIN (GPT_MIN),
                .GPT_MAX (GPT_MAX)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .i_gate       (gate[k]),
                .i_trig       (trig),
                .i_clear      (clear),
                .i_eval       (w_eval),
                .o_err_now    (w_err_now[k]),
                .o_time_err   (time_err[k]),
                .o_err_sticky (err_sticky[k]),
                .o_last_count (last_count[k*CW +: CW])
            );
        end
    endgenerate

    assign valid     = r_valid;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_gpt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpt_monitor
//  Description : Self-checking bench for gpt_monitor. Three configurations
//                share the same stimulus: defaults (a), window 14..18 with a
//                2-bit error counter (b), and a 4-bit gate counter (c).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpt_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  gate = '0;
    logic        trig = 1'b0;
    logic        clear = 1'b0;

    logic        valid_a, valid_b, valid_c;
    logic [3:0]  te_a, te_b, te_c, st_a, st_b, st_c;
    logic [15:0] ec_a, ec_c;
    logic [1:0]  ec_b;
    logic [35:0] lc_a, lc_b;
    logic [15:0] lc_c;

    gpt_monitor u_a (
        .clk(clk), .rst(rst), .gate(gate), .trig(trig), .clear(clear),
        .valid(valid_a), .time_err(te_a), .err_sticky(st_a),
        .err_count(ec_a), .last_count(lc_a)
    );

    gpt_monitor #(.GPT_MIN(14), .GPT_MAX(18), .ECW(2)) u_b (
        .clk(clk), .rst(rst), .gate(gate), .trig(trig), .clear(clear),
        .valid(valid_b), .time_err(te_b), .err_sticky(st_b),
        .err_count(ec_b), .last_count(lc_b)
    );

    gpt_monitor #(.CW(4), .GPT_MIN(10), .GPT_MAX(12)) u_c (
        .clk(clk), .rst(rst), .gate(gate), .trig(trig), .clear(clear),
        .valid(valid_c), .time_err(te_c), .err_sticky(st_c),
        .err_count(ec_c), .last_count(lc_c)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state, one slot per configuration.
    logic [31:0] sb_q[$];
    bit          m_synced;
    logic [3:0]  m_terr[3];
    logic [3:0]  m_sticky[3];
    int          m_ec[3];
    int          m_lc[3][4];

    // Sampled outputs of the configuration under test.
    logic        o_v;
    logic [3:0]  o_te, o_st;
    int          o_ec;
    int          o_lc[4];

    function automatic int p_cw(input int d);
        return (d == 2) ? 4 : 9;
    endfunction
    function automatic int p_min(input int d);
        case (d) 1: return 14; 2: return 10; default: return 16; endcase
    endfunction
    function automatic int p_max(input int d);
        case (d) 1: return 18; 2: return 12; default: return 16; endcase
    endfunction
    function automatic int p_ecmax(input int d);
        return (d == 1) ? 3 : 65535;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int d);
        case (d)
            1: begin
                o_v = valid_b; o_te = te_b; o_st = st_b; o_ec = int'(ec_b);
                for (int k = 0; k < 4; k++) o_lc[k] = int'(lc_b[k*9 +: 9]);
            end
            2: begin
                o_v = valid_c; o_te = te_c; o_st = st_c; o_ec = int'(ec_c);
                for (int k = 0; k < 4; k++) o_lc[k] = int'(lc_c[k*4 +: 4]);
            end
            default: begin
                o_v = valid_a; o_te = te_a; o_st = st_a; o_ec = int'(ec_a);
                for (int k = 0; k < 4; k++) o_lc[k] = int'(lc_a[k*9 +: 9]);
            end
        endcase
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_synced = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_terr[i] = '0; m_sticky[i] = '0; m_ec[i] = 0;
            for (int k = 0; k < 4; k++) m_lc[i][k] = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; gate = '0; trig = 1'b0; clear = 1'b0;
        step(); step();
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one interval with the given gate totals per channel, then the
    // trig. With coinc set, each non-zero channel places its last gate on the
    // trig cycle. The expectation is queued as the trig is driven and checked
    // when the result appears.
    task automatic run_interval(input int d, input int c0, input int c1,
                                input int c2, input int c3, input bit coinc);
        int          g[4];
        int          pre[4];
        int          len;
        bit          exp_eval;
        logic [31:0] e;
        int          tot;
        int          lim;
        logic [3:0]  et;
        g[0] = c0; g[1] = c1; g[2] = c2; g[3] = c3;
        len = 0;
        for (int k = 0; k < 4; k++) begin
            pre[k] = (coinc && g[k] > 0) ? g[k] - 1 : g[k];
            if (pre[k] > len) len = pre[k];
        end
        for (int c = 0; c < len; c++) begin
            for (int k = 0; k < 4; k++) gate[k] = (c < pre[k]);
            step();
        end
        for (int k = 0; k < 4; k++) gate[k] = coinc && (g[k] > 0);
        trig = 1'b1;
        exp_eval = m_synced;
        if (m_synced) sb_q.push_back({8'(g[3]), 8'(g[2]), 8'(g[1]), 8'(g[0])});
        else m_synced = 1'b1;
        step();
        trig = 1'b0;
        gate = '0;
        sample(d);
        if (!exp_eval) begin
            checks++;
            if (o_v !== 1'b0 || o_te !== m_terr[d]) begin
                errors++;
                $display("FAIL sync_trig: valid=%b time_err=%b, required valid=0 time_err=%b",
                         o_v, o_te, m_terr[d]);
            end
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                lim = (2 ** p_cw(i)) - 1;
                et = '0;
                for (int k = 0; k < 4; k++) begin
                    tot = int'(e[k*8 +: 8]);
                    if (tot > lim) tot = lim;
                    et[k] = (tot < p_min(i)) || (tot > p_max(i));
                    m_lc[i][k] = tot;
                end
                m_terr[i] = et;
                m_sticky[i] = m_sticky[i] | et;
                if (et != 4'b0 && m_ec[i] < p_ecmax(i)) m_ec[i]++;
            end
            checks++;
            if (o_v !== 1'b1) begin
                errors++; $display("FAIL eval_valid: got %b required 1", o_v);
            end
            checks++;
            if (o_te !== m_terr[d]) begin
                errors++; $display("FAIL eval_time_err: got %b required %b", o_te, m_terr[d]);
            end
            checks++;
            if (o_st !== m_sticky[d]) begin
                errors++; $display("FAIL eval_sticky: got %b required %b", o_st, m_sticky[d]);
            end
            checks++;
            if (o_ec != m_ec[d]) begin
                errors++; $display("FAIL eval_err_count: got %0d required %0d", o_ec, m_ec[d]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (o_lc[k] != m_lc[d][k]) begin
                    errors++;
                    $display("FAIL eval_last_count ch%0d: got %0d required %0d", k, o_lc[k], m_lc[d][k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < 3; d++) begin
            sample(d);
            checks++;
            if (o_v !== 1'b0 || o_te !== 4'b0 || o_st !== 4'b0 || o_ec != 0 ||
                o_lc[0] != 0 || o_lc[1] != 0 || o_lc[2] != 0 || o_lc[3] != 0) begin
                errors++;
                $display("FAIL reset_state dut%0d: valid=%b te=%b st=%b ec=%0d lc0=%0d, required all zero",
                         d, o_v, o_te, o_st, o_ec, o_lc[0]);
            end
        end
    endtask

    task automatic test_nominal();
        for (int n = 0; n < 4; n++) run_interval(0, 16, 16, 16, 16, 1'b0);
        step();
        sample(0);
        checks++;
        if (o_v !== 1'b0 || o_te !== 4'b0 || o_lc[3] != 16 || o_ec != 0) begin
            errors++;
            $display("FAIL nominal_hold: valid=%b te=%b lc3=%0d ec=%0d, required 0 0000 16 0",
                     o_v, o_te, o_lc[3], o_ec);
        end
    endtask

    task automatic test_errors();
        run_interval(0, 17, 16, 15, 16, 1'b0);
        checks++;
        if (o_te !== 4'b0101 || o_st !== 4'b0101 || o_ec != 1) begin
            errors++;
            $display("FAIL errors_flag: te=%b st=%b ec=%0d, required 0101 0101 1", o_te, o_st, o_ec);
        end
        run_interval(0, 16, 16, 16, 16, 1'b0);
        checks++;
        if (o_te !== 4'b0000 || o_st !== 4'b0101 || o_ec != 1) begin
            errors++;
            $display("FAIL errors_sticky: te=%b st=%b ec=%0d, required 0000 0101 1", o_te, o_st, o_ec);
        end
    endtask

    task automatic test_window();
        run_interval(1, 14, 18, 13, 19, 1'b1);
        checks++;
        if (o_te !== 4'b1100 || o_lc[3] != 19 || o_lc[2] != 13 || o_lc[1] != 18 || o_lc[0] != 14) begin
            errors++;
            $display("FAIL window: te=%b lc=%0d,%0d,%0d,%0d, required 1100 19,13,18,14",
                     o_te, o_lc[3], o_lc[2], o_lc[1], o_lc[0]);
        end
    endtask

    task automatic test_saturate();
        run_interval(2, 40, 40, 40, 40, 1'b0);
        checks++;
        if (o_te !== 4'b1111 || o_lc[0] != 15 || o_lc[3] != 15) begin
            errors++;
            $display("FAIL saturate: te=%b lc0=%0d lc3=%0d, required 1111 15 15", o_te, o_lc[0], o_lc[3]);
        end
    endtask

    task automatic test_back_to_back();
        run_interval(0, 16, 16, 16, 16, 1'b0);
        run_interval(0, 1, 0, 1, 0, 1'b1);
        checks++;
        if (o_lc[0] != 1 || o_lc[1] != 0 || o_lc[2] != 1 || o_lc[3] != 0 || o_te !== 4'b1111) begin
            errors++;
            $display("FAIL back_to_back: lc=%0d,%0d,%0d,%0d te=%b, required 0,1,0,1 1111",
                     o_lc[3], o_lc[2], o_lc[1], o_lc[0], o_te);
        end
    endtask

    task automatic test_clear();
        gate = 4'hF;
        for (int c = 0; c < 5; c++) step();
        clear = 1'b1;
        trig = 1'b1;
        step();
        clear = 1'b0; trig = 1'b0; gate = '0;
        m_synced = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_sticky[i] = '0; m_ec[i] = 0;
        end
        sample(0);
        checks++;
        if (o_v !== 1'b0 || o_st !== 4'b0 || o_ec != 0 || o_te !== m_terr[0] || o_lc[0] != m_lc[0][0]) begin
            errors++;
            $display("FAIL clear_trig: valid=%b st=%b ec=%0d te=%b lc0=%0d, required 0 0000 0 %b %0d",
                     o_v, o_st, o_ec, o_te, o_lc[0], m_terr[0], m_lc[0][0]);
        end
        run_interval(0, 16, 16, 16, 16, 1'b0);
        run_interval(0, 16, 16, 16, 16, 1'b0);
    endtask

    task automatic test_rst_mid();
        gate = 4'hF;
        for (int c = 0; c < 7; c++) step();
        apply_reset();
        run_interval(0, 16, 16, 16, 16, 1'b0);
        run_interval(0, 16, 16, 16, 16, 1'b0);
        checks++;
        if (o_lc[0] != 16 || o_te !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid: lc0=%0d te=%b, required 16 0000", o_lc[0], o_te);
        end
    endtask

    task automatic test_ecw();
        int exp_seq[4];
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 3;
        apply_reset();
        run_interval(1, 20, 20, 20, 20, 1'b0);
        for (int n = 0; n < 4; n++) begin
            run_interval(1, 20, 20, 20, 20, 1'b0);
            checks++;
            if (o_ec != exp_seq[n]) begin
                errors++;
                $display("FAIL ecw_seq step%0d: got %0d required %0d", n, o_ec, exp_seq[n]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_errors();
        test_window();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_rst_mid();
        test_ecw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
